// File: rtl/bitstream_unstuffer.sv
// bitstream_unstuffer: fetches packed SRAM words, strips the 0x00 stuffed after 0xFF, and exposes an MSB-first peek/consume bit window.
module bitstream_unstuffer #(
  parameter int ADDR_W = 12,
  parameter int BUF_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_cnt,
  output logic              sram_re,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_rdata,
  output logic [15:0]       peek,
  output logic [6:0]        avail,
  input  logic              consume_en,
  input  logic [4:0]        consume,
  output logic              busy,
  output logic              fill_done,
  output logic              marker_err,
  output logic [7:0]        marker,
  output logic              protocol_err
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, BYTES, FILL_DONE} state_t;
  localparam logic [ADDR_W-1:0] ONE = 1;
  state_t state;
  logic [ADDR_W-1:0] addr, rem;
  logic [31:0] hold;
  logic [1:0] bidx;
  logic ff_prev;
  logic [BUF_W-1:0] buf_q, buf_sh;
  logic [6:0] cnt, cnt_sh;
  logic cons_ok, can_app;
  logic [7:0] cur;
  assign peek = buf_q[BUF_W-1 -: 16];
  assign avail = cnt;
  always_comb begin
    cons_ok = consume_en && consume != 5'd0 && {2'b0, consume} <= cnt;
    cnt_sh = cons_ok ? cnt - {2'b0, consume} : cnt;
    buf_sh = cons_ok ? buf_q << consume : buf_q;
    can_app = cnt_sh <= 7'(BUF_W - 8);
    cur = hold[31:24];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      hold <= '0;
      bidx <= '0;
      ff_prev <= 1'b0;
      buf_q <= '0;
      cnt <= '0;
      sram_re <= 1'b0;
      sram_addr <= '0;
      busy <= 1'b0;
      fill_done <= 1'b0;
      marker_err <= 1'b0;
      marker <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (consume_en && {2'b0, consume} > cnt) protocol_err <= 1'b1;
      buf_q <= buf_sh;
      cnt <= cnt_sh;
      case (state)
        IDLE: if (start) begin
          marker_err <= 1'b0;
          protocol_err <= 1'b0;
          fill_done <= 1'b0;
          buf_q <= '0;
          cnt <= '0;
          ff_prev <= 1'b0;
          busy <= 1'b1;
          if (word_cnt == '0) begin
            state <= FILL_DONE;
            fill_done <= 1'b1;
          end else begin
            state <= REQ;
            sram_re <= 1'b1;
            sram_addr <= base_addr;
            addr <= base_addr + ONE;
            rem <= word_cnt - ONE;
          end
        end
        REQ: begin
          sram_re <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          hold <= sram_rdata;
          bidx <= '0;
          state <= BYTES;
        end
        BYTES: if (ff_prev && cur != 8'h00) begin
          marker_err <= 1'b1;
          marker <= cur;
          state <= FILL_DONE;
          fill_done <= 1'b1;
        end else if (ff_prev || can_app) begin
          // a stuffed 0x00 is dropped without needing buffer room
          if (ff_prev) ff_prev <= 1'b0;
          else begin
            buf_q <= buf_sh | ({cur, {(BUF_W-8){1'b0}}} >> cnt_sh);
            cnt <= cnt_sh + 7'd8;
            ff_prev <= cur == 8'hFF;
          end
          hold <= hold << 8;
          bidx <= bidx + 2'd1;
          if (bidx == 2'd3) begin
            if (rem != '0) begin
              state <= REQ;
              sram_re <= 1'b1;
              sram_addr <= addr;
              addr <= addr + ONE;
              rem <= rem - ONE;
            end else begin
              state <= FILL_DONE;
              fill_done <= 1'b1;
            end
          end
        end
        FILL_DONE: if (cnt == 7'd0) begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bitstream_unstuffer.sv
// tb_bitstream_unstuffer: randomized and directed streams checked by a bit-queue scoreboard fed from a byte-level reference model.
module tb_bitstream_unstuffer;
  localparam int ADDR_W = 12;
  logic clk = 0, rst = 0, start = 0, consume_en = 0;
  logic [ADDR_W-1:0] base_addr = '0, word_cnt = '0;
  logic sram_re, busy, fill_done, marker_err, protocol_err;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0] sram_rdata = '0;
  logic [15:0] peek;
  logic [6:0] avail;
  logic [4:0] consume = '0;
  logic [7:0] marker;
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] words[$];
  bit exp_bits[$];
  int script[$];
  int checks = 0, errors = 0, rd_total = 0, mode = 0;
  bit chk_en = 0;

  bitstream_unstuffer #(.ADDR_W(ADDR_W), .BUF_W(64)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
    .sram_re(sram_re), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .peek(peek), .avail(avail), .consume_en(consume_en), .consume(consume),
    .busy(busy), .fill_done(fill_done), .marker_err(marker_err), .marker(marker),
    .protocol_err(protocol_err));

  always #5 clk = ~clk;

  always @(posedge clk) if (sram_re) begin
    sram_rdata <= mem[sram_addr];
    rd_total <= rd_total + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor and consumer: peek must equal the next expected bits
  initial forever begin
    int a, n, k, mn;
    logic [15:0] e;
    @(negedge clk);
    consume_en = 0;
    consume = 0;
    if (chk_en && rst) begin
      a = int'(avail);
      n = exp_bits.size();
      e = '0;
      for (int i = 0; i < 16; i++) if (i < a && i < n) e[15-i] = exp_bits[i];
      checks++;
      if (a > 64 || a > n || peek !== e) begin
        errors++;
        $display("FAIL peek: avail=%0d peek=%h expected peek=%h with %0d bits outstanding", a, peek, e, n);
      end
      k = 0;
      mn = a < 16 ? a : 16;
      case (mode)
        1: k = a >= 8 ? 8 : 0;
        2: k = (a == 0 || $urandom_range(3) == 0) ? 0 : int'($urandom_range(mn, 1));
        3: k = a >= 16 ? 16 : 0;
        4: if (script.size() > 0) k = script.pop_front();
        default: k = 0;
      endcase
      if (k > 0) begin
        consume_en = 1;
        consume = 5'(k);
        if (k <= a) repeat (k) void'(exp_bits.pop_front());
      end
    end
  end

  task automatic build_ref(input logic [ADDR_W-1:0] base, output int nreads, output bit merr, output logic [7:0] mk);
    bit ff;
    logic [7:0] by;
    ff = 0; merr = 0; mk = 0; nreads = words.size();
    for (int i = 0; i < words.size(); i++) mem[base + ADDR_W'(i)] = words[i];
    for (int i = 0; i < words.size() && !merr; i++)
      for (int b = 0; b < 4 && !merr; b++) begin
        by = 8'(words[i] >> (24 - 8*b));
        if (ff && by == 8'h00) ff = 0;
        else if (ff) begin merr = 1; mk = by; nreads = i + 1; end
        else begin
          for (int j = 7; j >= 0; j--) exp_bits.push_back(by[j]);
          ff = by == 8'hFF;
        end
      end
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] base, input int n);
    @(negedge clk);
    start = 1; base_addr = base; word_cnt = ADDR_W'(n);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int c = 0;
    while ((busy || !fill_done) && c < max) begin @(negedge clk); c++; end
    if (c >= max) chk({name, " timeout"}, 1, 0);
  endtask

  task automatic finish_checks(input string name, input int r0, input int nreads, input bit merr, input logic [7:0] mk, input logic [ADDR_W-1:0] base);
    chk({name, " fill_done"}, fill_done, 1);
    chk({name, " busy"}, busy, 0);
    chk({name, " avail"}, avail, 0);
    chk({name, " marker_err"}, marker_err, merr);
    if (merr) chk({name, " marker"}, marker, mk);
    chk({name, " reads"}, rd_total - r0, nreads);
    if (nreads > 0) chk({name, " last addr"}, sram_addr, base + ADDR_W'(nreads - 1));
    chk({name, " leftover bits"}, exp_bits.size(), 0);
  endtask

  task automatic run_stream(input string name, input logic [ADDR_W-1:0] base, input int m);
    int nreads, r0;
    bit merr;
    logic [7:0] mk;
    build_ref(base, nreads, merr, mk);
    mode = m;
    r0 = rd_total;
    pulse_start(base, words.size());
    wait_idle(name, 3000);
    finish_checks(name, r0, nreads, merr, mk, base);
    chk({name, " protocol_err"}, protocol_err, 0);
  endtask

  initial begin
    int nreads, r0, c;
    bit merr;
    logic [7:0] mk, by;
    logic [31:0] w;
    repeat (3) @(negedge clk);
    chk("reset sram_re", sram_re, 0);
    chk("reset peek/avail", {peek, 9'd0, avail}, 0);
    chk("reset flags", {busy, fill_done, marker_err, marker, protocol_err, sram_addr}, 0);
    rst = 1;
    chk_en = 1;

    words = '{32'h4F8E1FF1, 32'h7C3FCF82, 32'hFF00CFFD, 32'hCC5FE751};
    run_stream("plan_basic", 12'h100, 1);
    words = '{32'h123456FF, 32'h00ABCDEF};
    run_stream("split_stuff", 12'h200, 1);
    words = '{32'hAAFFD9BB, 32'h11223344};
    run_stream("marker", 12'h300, 1);

    words = {};
    repeat (16) words.push_back(32'h5A5A5A5A);
    build_ref(12'h400, nreads, merr, mk);
    mode = 0;
    r0 = rd_total;
    pulse_start(12'h400, 16);
    repeat (60) @(negedge clk);
    chk("stall avail", avail, 64);
    chk("stall reads", rd_total - r0, 3);
    mode = 3;
    wait_idle("stall", 3000);
    finish_checks("stall", r0, nreads, merr, mk, 12'h400);

    words = '{32'hA1B2C3D4};
    build_ref(12'h500, nreads, merr, mk);
    mode = 4;
    r0 = rd_total;
    pulse_start(12'h500, 1);
    c = 0;
    while (avail != 7'd32 && c < 50) begin @(negedge clk); c++; end
    chk("proto fill", avail, 32);
    script = '{16, 12};
    repeat (4) @(negedge clk);
    chk("proto avail4", avail, 4);
    chk("proto err before", protocol_err, 0);
    script = '{9};
    repeat (3) @(negedge clk);
    chk("proto err", protocol_err, 1);
    chk("proto avail kept", avail, 4);
    script = '{4};
    wait_idle("proto", 50);
    finish_checks("proto", r0, nreads, merr, mk, 12'h500);
    chk("proto err sticky", protocol_err, 1);

    for (int t = 0; t < 8; t++) begin
      words = {};
      repeat ($urandom_range(8, 1)) begin
        for (int b = 0; b < 4; b++) begin
          c = int'($urandom_range(9));
          by = c < 2 ? 8'hFF : (c < 4 ? 8'h00 : 8'($urandom));
          w = {w[23:0], by};
        end
        words.push_back(w);
      end
      run_stream("random", t == 0 ? 12'hFFE : ADDR_W'($urandom), 2);
    end

    words = '{32'h01020304, 32'h05060708};
    build_ref(12'h600, nreads, merr, mk);
    mode = 1;
    pulse_start(12'h600, 2);
    c = 0;
    while (!sram_re && c < 10) begin @(negedge clk); c++; end
    chk("rst setup sram_re", sram_re, 1);
    @(posedge clk);
    #1 chk_en = 0; rst = 0;
    #1;
    chk("rst sram_re", sram_re, 0);
    chk("rst sram_addr", sram_addr, 0);
    chk("rst peek/avail", {peek, avail}, 0);
    chk("rst status", {busy, fill_done, marker_err, marker, protocol_err}, 0);
    @(negedge clk);
    rst = 1;
    exp_bits.delete();
    chk_en = 1;
    repeat (3) @(negedge clk);
    chk("post rst avail", avail, 0);

    r0 = rd_total;
    pulse_start(12'h700, 0);
    chk("empty fill_done", fill_done, 1);
    wait_idle("empty", 10);
    chk("empty busy", busy, 0);
    chk("empty reads", rd_total - r0, 0);
    chk("empty sram_re", sram_re, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
